// File: rtl/gray_sync_bus_rx.sv
// Receive side of a Gray-coded pointer crossing: N-flop synchronizer into q_clk,
// Gray->binary conversion, optional output register and a change pulse.
`timescale 1ns/1ps
module gray_sync_bus_rx #(
  parameter int WIDTH        = 8,
  parameter int EXTRA_STAGES = 1,
  parameter int REG_OUT      = 1
) (
  input  logic             q_clk,
  input  logic             q_rst_n,
  input  logic             q_clr,
  input  logic [WIDTH-1:0] d_gray,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             q_chg
);

  localparam int N = 2 + EXTRA_STAGES;

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync [N];
  logic [WIDTH-1:0] q_next;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Synchronizer chain: pure flop-to-flop, no logic between stages
  always_ff @(posedge q_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      for (int i = 0; i < N; i++) sync[i] <= '0;
    end else if (q_clr) begin
      for (int i = 0; i < N; i++) sync[i] <= '0;
    end else begin
      sync[0] <= d_gray;
      for (int i = 1; i < N; i++) sync[i] <= sync[i-1];
    end
  end

  assign q_gray = sync[N-1];

  // q_next is the value q will take on the coming edge, so q_chg lines up with q
  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] q_reg;
    assign q_next = gray2bin(sync[N-1]);
    always_ff @(posedge q_clk or negedge q_rst_n) begin
      if (!q_rst_n)   q_reg <= '0;
      else if (q_clr) q_reg <= '0;
      else            q_reg <= q_next;
    end
    assign q = q_reg;
  end else begin : g_comb_out
    assign q_next = gray2bin(sync[N-2]);
    assign q      = gray2bin(sync[N-1]);
  end

  always_ff @(posedge q_clk or negedge q_rst_n) begin
    if (!q_rst_n)   q_chg <= 1'b0;
    else if (q_clr) q_chg <= 1'b0;
    else            q_chg <= (q_next != q);
  end

`ifdef SIMULATION
  // Disarmed after reset/clear so the first refill sample is not flagged
  logic armed;
  always_ff @(posedge q_clk or negedge q_rst_n) begin
    if (!q_rst_n) begin
      armed <= 1'b0;
    end else if (q_clr) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (armed && ($countones(d_gray ^ sync[0]) > 1))
        $display("gray_sync_bus_rx: error, stage 0 moved %0d bits (%h -> %h)",
                 $countones(d_gray ^ sync[0]), sync[0], d_gray);
    end
  end
`endif

endmodule

// File: tb/tb_gray_sync_bus_rx.sv
// Randomized bench for gray_sync_bus_rx: default build (LAT=4) and a minimal
// build (EXTRA_STAGES=0, REG_OUT=0, LAT=2) share the same stimulus.
`timescale 1ns/1ps
module tb_gray_sync_bus_rx;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] d_gray;
  logic [7:0] q, q_gray, q2, q_gray2;
  logic       q_chg, q_chg2;

  gray_sync_bus_rx #(.WIDTH(8), .EXTRA_STAGES(1), .REG_OUT(1)) dut (
    .q_clk(clk), .q_rst_n(rst_n), .q_clr(clr), .d_gray(d_gray),
    .q(q), .q_gray(q_gray), .q_chg(q_chg));

  gray_sync_bus_rx #(.WIDTH(8), .EXTRA_STAGES(0), .REG_OUT(0)) dut2 (
    .q_clk(clk), .q_rst_n(rst_n), .q_clr(clr), .d_gray(d_gray),
    .q(q2), .q_gray(q_gray2), .q_chg(q_chg2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Binary bit i is the XOR of all Gray bits at or above i
  function automatic logic [7:0] ref_bin(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  // Reference: edges since last clear/reset and the d_gray seen at each edge
  int         since = 0;
  logic [7:0] hist [8] = '{default: 8'h00};
  logic [7:0] e4 = 0, e2 = 0;
  logic       c4, c2;

  task automatic tick();
    logic [7:0] p4, p2;
    @(posedge clk);
    if (!rst_n || clr) since = 0;
    else since++;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d_gray;
    p4 = e4;
    p2 = e2;
    e4 = (since >= 4) ? ref_bin(hist[3]) : 8'h00;
    e2 = (since >= 2) ? ref_bin(hist[1]) : 8'h00;
    c4 = rst_n && !clr && (e4 != p4);
    c2 = rst_n && !clr && (e2 != p2);
    @(negedge clk);
    chk_eq("q",       q,       e4);
    chk_eq("q_gray",  q_gray,  (since >= 3) ? hist[2] : 8'h00);
    chk_eq("q_chg",   q_chg,   c4);
    chk_eq("q2",      q2,      e2);
    chk_eq("q_gray2", q_gray2, (since >= 2) ? hist[1] : 8'h00);
    chk_eq("q_chg2",  q_chg2,  c2);
  endtask

  // Asynchronous counting source; checks only that q is held and monotonic
  bit         held [256];
  bit         sweep_done;
  logic [7:0] prev4, prev2;

  task automatic async_sweep(input realtime per);
    for (int i = 0; i < 256; i++) held[i] = 1'b0;
    held[0]    = 1'b1;
    sweep_done = 1'b0;
    prev4      = 8'h00;
    prev2      = 8'h00;
    fork
      begin
        #0.13;
        for (int v = 1; v < 256; v++) begin
          #(per);
          held[v] = 1'b1;
          d_gray  = 8'(v ^ (v >> 1));
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(negedge clk);
          chk_eq("sweep_held",  32'(held[q]),  1);
          chk_eq("sweep_held2", 32'(held[q2]), 1);
          chk_eq("sweep_mono",  32'(8'(q - prev4) < 8'd128), 1);
          chk_eq("sweep_mono2", 32'(8'(q2 - prev2) < 8'd128), 1);
          prev4 = q;
          prev2 = q2;
        end
      end
    join
    repeat (6) @(negedge clk);
    chk_eq("sweep_end",  q,  8'hFF);
    chk_eq("sweep_end2", q2, 8'hFF);
  endtask

  task automatic restart(input logic [7:0] g);
    d_gray = g;
    clr    = 1'b1;
    tick();
    clr    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses;

  initial begin
    rst_n  = 1'b0;
    clr    = 1'b0;
    d_gray = 8'h00;
    repeat (3) tick();
    chk_eq("rst_q",   q,     8'h00);
    chk_eq("rst_chg", q_chg, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Latency step 0x00 -> 0x01
    d_gray = 8'h01;
    tick();
    tick();
    chk_eq("lat_min_q", q2, 8'h01);
    tick();
    chk_eq("lat_e3_q", q, 8'h00);
    tick();
    chk_eq("lat_e4_q",   q,     8'h01);
    chk_eq("lat_e4_chg", q_chg, 1'b1);
    tick();
    chk_eq("lat_e5_chg", q_chg, 1'b0);

    // Wrap-around: binary 255 -> 0
    restart(8'h80);
    repeat (6) tick();
    chk_eq("wrap_ff", q, 8'hFF);
    d_gray = 8'h00;
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += int'(q_chg);
    end
    chk_eq("wrap_q", q, 8'h00);
    chk_eq("wrap_pulses", pulses, 1);

    // Clear while holding binary 8
    restart(8'h0C);
    repeat (6) tick();
    chk_eq("clr_pre", q, 8'h08);
    clr = 1'b1;
    tick();
    chk_eq("clr_q", q, 8'h00);
    clr    = 1'b0;
    pulses = 0;
    repeat (3) begin
      tick();
      pulses += int'(q_chg);
    end
    chk_eq("clr_hold", q, 8'h00);
    repeat (3) begin
      tick();
      pulses += int'(q_chg);
    end
    chk_eq("clr_back", q, 8'h08);
    chk_eq("clr_pulses", pulses, 1);

    // Asynchronous reset mid-run
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_q",      q,      8'h00);
    chk_eq("arst_q_gray", q_gray, 8'h00);
    chk_eq("arst_chg",    q_chg,  1'b0);
    chk_eq("arst_q2",     q2,     8'h00);
    @(negedge clk);
    d_gray = 8'h07;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk_eq("arst_refill", q, 8'h05);

    // Random single-bit walk with occasional clears
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) d_gray = d_gray ^ (8'h01 << $urandom_range(0, 7));
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    clr = 1'b0;

    // Counter sweeps from an unrelated source clock (0.7x and 1.9x)
    restart(8'h00);
    repeat (6) tick();
    async_sweep(14.29);
    restart(8'h00);
    repeat (6) tick();
    async_sweep(5.27);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
